// File: rtl/vga_timing_multi.sv
// vga_timing_multi: dual-mode VGA timing generator (counters, sync, blanking).
// Two video modes are fixed at elaboration. The runtime switch between them
// only takes effect on a frame wrap, so a frame is never output with mixed
// timing.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_multi #(
   parameter int CNT_W           = 11,
   parameter int M0_H_ACTIVE     = 1024,
   parameter int M0_H_SYNC_START = 1048,
   parameter int M0_H_SYNC_END   = 1184,
   parameter int M0_H_TOTAL      = 1344,
   parameter int M0_V_ACTIVE     = 768,
   parameter int M0_V_SYNC_START = 771,
   parameter int M0_V_SYNC_END   = 777,
   parameter int M0_V_TOTAL      = 806,
   parameter bit M0_HSYNC_POL    = 1'b0,
   parameter bit M0_VSYNC_POL    = 1'b0,
   parameter int M1_H_ACTIVE     = 800,
   parameter int M1_H_SYNC_START = 840,
   parameter int M1_H_SYNC_END   = 968,
   parameter int M1_H_TOTAL      = 1056,
   parameter int M1_V_ACTIVE     = 600,
   parameter int M1_V_SYNC_START = 601,
   parameter int M1_V_SYNC_END   = 605,
   parameter int M1_V_TOTAL      = 628,
   parameter bit M1_HSYNC_POL    = 1'b1,
   parameter bit M1_VSYNC_POL    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode_sel,
   input  logic             mode_req,
   output logic             mode_ack,
   output logic             cur_mode,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   // Per-mode timing lookups; the argument is the mode bit.
   function automatic logic [CNT_W-1:0] f_h_last(input logic m);
      return m ? CNT_W'(M1_H_TOTAL - 1) : CNT_W'(M0_H_TOTAL - 1);
   endfunction

   function automatic logic [CNT_W-1:0] f_v_last(input logic m);
      return m ? CNT_W'(M1_V_TOTAL - 1) : CNT_W'(M0_V_TOTAL - 1);
   endfunction

   function automatic logic [CNT_W-1:0] f_h_act(input logic m);
      return m ? CNT_W'(M1_H_ACTIVE) : CNT_W'(M0_H_ACTIVE);
   endfunction

   function automatic logic [CNT_W-1:0] f_v_act(input logic m);
      return m ? CNT_W'(M1_V_ACTIVE) : CNT_W'(M0_V_ACTIVE);
   endfunction

   function automatic logic f_hsync(input logic m, input logic [CNT_W-1:0] h);
      logic [CNT_W-1:0] s, e;
      logic             p;
      s = m ? CNT_W'(M1_H_SYNC_START) : CNT_W'(M0_H_SYNC_START);
      e = m ? CNT_W'(M1_H_SYNC_END)   : CNT_W'(M0_H_SYNC_END);
      p = m ? M1_HSYNC_POL : M0_HSYNC_POL;
      return ((h >= s) && (h < e)) ? p : ~p;
   endfunction

   function automatic logic f_vsync(input logic m, input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] s, e;
      logic             p;
      s = m ? CNT_W'(M1_V_SYNC_START) : CNT_W'(M0_V_SYNC_START);
      e = m ? CNT_W'(M1_V_SYNC_END)   : CNT_W'(M0_V_SYNC_END);
      p = m ? M1_VSYNC_POL : M0_VSYNC_POL;
      return ((v >= s) && (v < e)) ? p : ~p;
   endfunction

   // r_run distinguishes the priming edge right after reset (which presents
   // pixel 0,0 with frame_start) from normal counting.
   logic             r_run;
   logic             r_cur_mode;
   logic             r_pend;
   logic             r_pend_mode;
   logic             r_ack;
   logic [CNT_W-1:0] r_hcount;
   logic [CNT_W-1:0] r_vcount;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_hblnk;
   logic             r_vblnk;
   logic             r_fs;

   logic             w_hend;
   logic             w_vend;
   logic             w_fwrap;
   logic             w_mode_nx;
   logic [CNT_W-1:0] w_h_nx;
   logic [CNT_W-1:0] w_v_nx;

   // Next pixel position and the mode that applies to it.
   always_comb begin
      w_hend    = (r_hcount == f_h_last(r_cur_mode));
      w_vend    = (r_vcount == f_v_last(r_cur_mode));
      w_fwrap   = r_run && w_hend && w_vend;
      w_mode_nx = (w_fwrap && r_pend) ? r_pend_mode : r_cur_mode;
      w_h_nx    = '0;
      w_v_nx    = '0;
      if (r_run) begin
         if (w_hend) begin
            w_h_nx = '0;
            w_v_nx = w_vend ? '0 : r_vcount + CNT_W'(1);
         end else begin
            w_h_nx = r_hcount + CNT_W'(1);
            w_v_nx = r_vcount;
         end
      end
   end

   // Mode-switch bookkeeping: a request always lands in the pending slot
   // (last wins); a request on the wrap edge is kept for the next wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run       <= 1'b0;
         r_cur_mode  <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_mode <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_run      <= 1'b1;
         r_cur_mode <= w_mode_nx;
         r_ack      <= w_fwrap && r_pend;
         if (mode_req) begin
            r_pend      <= 1'b1;
            r_pend_mode <= mode_sel;
         end else if (w_fwrap) begin
            r_pend <= 1'b0;
         end
      end
   end

   // Counters plus sync/blank/frame_start, all derived from the next position
   // so every output lines up with hcount/vcount on the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hcount <= '0;
         r_vcount <= '0;
         r_hsync  <= ~M0_HSYNC_POL;
         r_vsync  <= ~M0_VSYNC_POL;
         r_hblnk  <= 1'b0;
         r_vblnk  <= 1'b0;
         r_fs     <= 1'b0;
      end else begin
         r_hcount <= w_h_nx;
         r_vcount <= w_v_nx;
         r_hsync  <= f_hsync(w_mode_nx, w_h_nx);
         r_vsync  <= f_vsync(w_mode_nx, w_v_nx);
         r_hblnk  <= (w_h_nx >= f_h_act(w_mode_nx));
         r_vblnk  <= (w_v_nx >= f_v_act(w_mode_nx));
         r_fs     <= !r_run || w_fwrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] r_fcnt;

   // Frames completed since reset, counting every wrap including mode switches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fcnt <= '0;
      end else if (w_fwrap) begin
         r_fcnt <= r_fcnt + 16'd1;
      end
   end

   assign frame_cnt = r_fcnt;
`endif

   assign mode_ack    = r_ack;
   assign cur_mode    = r_cur_mode;
   assign hcount      = r_hcount;
   assign vcount      = r_vcount;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign hblnk       = r_hblnk;
   assign vblnk       = r_vblnk;
   assign frame_start = r_fs;

endmodule

// File: doc/vga_timing_multi.md
# vga_timing_multi

Parametrised VGA timing generator, successor to the fixed 1024x768 timing constants used by the game's display path. It produces horizontal/vertical counters, sync and blanking for one of two compile-time-configured video modes, selected at runtime with a frame-boundary-safe switch handshake. It sits at the head of the video pipeline, driving the background, goalkeeper and overlay draw stages.

## Interface
Parameters (mode 0 defaults: 1024x768 @ 65 MHz; mode 1 defaults: 800x600):
- CNT_W, 11, width of hcount/vcount; every total must be ≤ 2^CNT_W
- M0_H_ACTIVE / M0_H_SYNC_START / M0_H_SYNC_END / M0_H_TOTAL, 1024 / 1048 / 1184 / 1344
- M0_V_ACTIVE / M0_V_SYNC_START / M0_V_SYNC_END / M0_V_TOTAL, 768 / 771 / 777 / 806
- M0_HSYNC_POL / M0_VSYNC_POL, 0 / 0, sync active level (0 = active-low)
- M1_H_ACTIVE / M1_H_SYNC_START / M1_H_SYNC_END / M1_H_TOTAL, 800 / 840 / 968 / 1056
- M1_V_ACTIVE / M1_V_SYNC_START / M1_V_SYNC_END / M1_V_TOTAL, 600 / 601 / 605 / 628
- M1_HSYNC_POL / M1_VSYNC_POL, 1 / 1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode_sel  in  1  requested mode, sampled when mode_req = 1
- mode_req  in  1  single-cycle mode-change request
- mode_ack  out  1  one-cycle pulse: requested mode now in effect
- cur_mode  out  1  mode of the timing currently output
- hcount  out  CNT_W  pixel index in line
- vcount  out  CNT_W  line index in frame
- hsync / vsync  out  1  sync, polarity per active mode
- hblnk / vblnk  out  1  blanking, active-high
- frame_start  out  1  high for the cycle where hcount = 0 and vcount = 0
- frame_cnt  out  16  frames since reset (only with macro, see Configuration)

## Operation
- hcount increments each clk; at H_TOTAL-1 wraps to 0 and vcount increments; vcount wraps to 0 after V_TOTAL-1 on the line-end cycle.
- hblnk = hcount ≥ H_ACTIVE; vblnk = vcount ≥ V_ACTIVE.
- hsync asserted (at POL level) when H_SYNC_START ≤ hcount < H_SYNC_END; vsync likewise on vcount. Deasserted level = !POL.
- Mode switch: mode_req latches mode_sel into a pending register and sets pending flag. A new request while pending overwrites the pending value (last wins). At the frame wrap (hcount = H_TOTAL-1 and vcount = V_TOTAL-1 of current mode) the pending mode is loaded into cur_mode, pending clears, and the first pixel of the new frame uses new-mode timing. Request equal to current mode is still acked at the next boundary.
- mode_req on the exact frame-wrap cycle: not applied this boundary; applied at the following one.
- Reset mid-frame: everything returns to reset values immediately; pending request discarded.

## Timing
- All outputs registered, same stage; hsync/blnk/frame_start are aligned with the hcount/vcount value on the same cycle (zero skew).
- Reset values: hcount = vcount = 0, cur_mode = 0, mode_ack = 0, hblnk = vblnk = 0, hsync = !M0_HSYNC_POL, vsync = !M0_VSYNC_POL, frame_start = 1 only after first clock edge post-reset is not required: frame_start = 0 during reset, and the first released cycle shows hcount = 0, vcount = 0, frame_start = 1.
- mode_ack is high on the same cycle as frame_start of the first new-mode frame, with cur_mode already updated.
- Mode-0 frame = 1344 × 806 = 1 083 264 clocks; mode 1 = 1056 × 628 = 663 168.

## Configuration
- VGA_FRAME_CNT_EN defined: frame_cnt port present; resets to 0, increments (wrapping at 16 bits) on every frame wrap, including mode-switch wraps.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, mode 0 -> hcount counts 0..1343, hblnk rises at 1024, hsync low for 1048..1183, vsync low for lines 771..776, frame_start every 1 083 264 clocks.
- mode_sel=1, mode_req pulse mid-frame -> no change until frame wrap; then mode_ack = 1, cur_mode = 1, hsync high for 840..967, H_TOTAL 1056.
- Two requests (1 then 0) within one frame -> at boundary cur_mode = 0, single mode_ack pulse.
- mode_req on frame-wrap cycle -> no switch at that wrap; switch and ack one frame later.
- rst_n low at hcount 500 / vcount 300 with request pending -> outputs at reset values immediately, after release mode 0 runs, no ack.
- With VGA_FRAME_CNT_EN: run 3 frames -> frame_cnt = 3; preload-free wrap check by forcing 0xFFFF -> 0 on next frame.
